// File: rtl/band_filt_seq.sv
// rtl/band_filt_seq.sv - sequencing controller for the per-band FIR filter bank
//
// Tracks the circular sample queue pointers. Once the queue has been filled
// with TAPS samples, every new sample launches one filter pass: `sequencing`
// is held high for CAP_IDX+1 cycles while `rd_ptr` walks the queue from the
// oldest sample to the newest. The filter outputs are captured on the last
// cycle of the window, and one idle cycle follows each pass so the next
// pass presents a fresh rising edge of `sequencing` to the filters.
//
// Optional build macro: OVR_FLAG_EN
//   defined   - `ovr` is a sticky overrun flag, cleared only by reset
//   undefined - `ovr` is tied to 0 and no overrun detection is built
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   smpl_vld   one-cycle strobe: a sample is written at `wr_ptr` this cycle
//   lft_filt   left filter output
//   rght_filt  right filter output
//   wr_ptr     queue write address
//   rd_ptr     queue read address presented to the filters
//   sequencing filter run enable (rising edge clears filter accumulators)
//   lft_out    captured left result
//   rght_out   captured right result
//   out_vld    one-cycle pulse when lft_out/rght_out update
//   ovr        sticky overrun flag (see OVR_FLAG_EN)
//
// CAP_IDX must not exceed TAPS: the read-pointer wrap uses one subtract.

module band_filt_seq #(
  parameter int TAPS    = 1021,
  parameter int PTR_W   = 10,
  parameter int CAP_IDX = 1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_vld,
  input  logic [15:0]      lft_filt,
  input  logic [15:0]      rght_filt,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             sequencing,
  output logic [15:0]      lft_out,
  output logic [15:0]      rght_out,
  output logic             out_vld,
  output logic             ovr
);

  localparam int CNT_W  = $clog2(CAP_IDX + 1);
  localparam int FILL_W = $clog2(TAPS + 1);
  // One spare bit above the wider operand so base + seq_cnt + 1 never overflows.
  localparam int SUM_W  = ((CNT_W > PTR_W) ? CNT_W : PTR_W) + 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic [CNT_W-1:0]  seq_cnt;
  logic [PTR_W-1:0]  base;
  logic [PTR_W-1:0]  wr_nxt;
  logic [PTR_W-1:0]  launch_base;
  logic [PTR_W-1:0]  rd_nxt;
  logic [SUM_W-1:0]  rd_sum;
  logic              pend;
  logic              launch;
  logic              capture;

  assign wr_nxt = (wr_ptr == PTR_W'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;

  // The oldest sample in the queue once this cycle's write (if any) lands.
  assign launch_base = smpl_vld ? wr_nxt : wr_ptr;

  // Read address for the next window cycle: (base + seq_cnt + 1) mod TAPS.
  assign rd_sum = SUM_W'(base) + SUM_W'(seq_cnt) + SUM_W'(1);
  assign rd_nxt = (rd_sum >= SUM_W'(TAPS)) ? PTR_W'(rd_sum - SUM_W'(TAPS))
                                           : PTR_W'(rd_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    capture    = 1'b0;
    sequencing = 1'b0;
    case (state)
      FILL: begin
        if (smpl_vld && (fill_cnt == FILL_W'(TAPS - 1))) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (smpl_vld) begin
          state_nxt = SEQ;
          launch    = 1'b1;
        end
      end
      SEQ: begin
        sequencing = 1'b1;
        if (seq_cnt == CNT_W'(CAP_IDX)) begin
          state_nxt = GAP;
          capture   = 1'b1;
        end
      end
      GAP: begin
        // A strobe landing in the gap cycle relaunches immediately, exactly
        // as a previously pending strobe does.
        if (pend || smpl_vld) begin
          state_nxt = SEQ;
          launch    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base     <= '0;
      seq_cnt  <= '0;
      fill_cnt <= '0;
      pend     <= 1'b0;
      lft_out  <= '0;
      rght_out <= '0;
      out_vld  <= 1'b0;
    end else begin
      if (smpl_vld) begin
        wr_ptr <= wr_nxt;
      end

      if ((state == FILL) && smpl_vld) begin
        fill_cnt <= fill_cnt + 1'b1;
      end

      if (launch) begin
        base    <= launch_base;
        rd_ptr  <= launch_base;
        seq_cnt <= '0;
      end else if ((state == SEQ) && !capture) begin
        seq_cnt <= seq_cnt + 1'b1;
        rd_ptr  <= rd_nxt;
      end

      if (capture) begin
        lft_out  <= lft_filt;
        rght_out <= rght_filt;
      end
      out_vld <= capture;

      // At most one pass is ever queued; launching consumes it.
      if (launch) begin
        pend <= 1'b0;
      end else if (smpl_vld && (state == SEQ)) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef OVR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (smpl_vld && pend) begin
      ovr <= 1'b1;
    end
  end
`else
  assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_band_filt_seq.sv
// tb/tb_band_filt_seq.sv - directed self-checking bench for band_filt_seq

module tb_band_filt_seq;

  logic        clk;
  logic        rst_n;
  logic        smpl_vld;
  logic [15:0] lft_filt;
  logic [15:0] rght_filt;
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        out_vld;
  logic        ovr;

  int n_cmp = 0;
  int n_err = 0;

`ifdef OVR_FLAG_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  band_filt_seq #(
    .TAPS    (8),
    .PTR_W   (3),
    .CAP_IDX (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_vld   (smpl_vld),
    .lft_filt   (lft_filt),
    .rght_filt  (rght_filt),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .out_vld    (out_vld),
    .ovr        (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},  32'(wr_ptr), 32'd0);
    check({tag, "_rd"},  32'(rd_ptr), 32'd0);
    check({tag, "_seq"}, 32'(sequencing), 32'd0);
    check({tag, "_lo"},  32'(lft_out), 32'd0);
    check({tag, "_ro"},  32'(rght_out), 32'd0);
    check({tag, "_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_ovr"}, 32'(ovr), 32'd0);
  endtask

  // Called right after the launching edge. Walks the 9-cycle window, driving
  // lb+k / rb+k as filter outputs at seq_cnt=k and strobing where mask[k] is
  // set. Returns in the GAP cycle after checking the captured result.
  task automatic run_pass(input int b, input logic [15:0] lb, input logic [15:0] rb,
                          input logic [8:0] mask);
    for (int k = 0; k <= 8; k++) begin
      check("pass_seq_hi", 32'(sequencing), 32'd1);
      check("pass_rd_ptr", 32'(rd_ptr), 32'((b + k) % 8));
      check("pass_vld_lo", 32'(out_vld), 32'd0);
      lft_filt  = lb + 16'(k);
      rght_filt = rb + 16'(k);
      smpl_vld  = mask[k];
      tick();
    end
    smpl_vld = 1'b0;
    check("gap_seq_lo",  32'(sequencing), 32'd0);
    check("gap_vld_hi",  32'(out_vld), 32'd1);
    check("gap_lft_out", 32'(lft_out), 32'(lb + 16'd8));
    check("gap_rgt_out", 32'(rght_out), 32'(rb + 16'd8));
    check("gap_rd_hold", 32'(rd_ptr), 32'((b + 8) % 8));
  endtask

  initial begin
    rst_n     = 1'b0;
    smpl_vld  = 1'b0;
    lft_filt  = 16'h0;
    rght_filt = 16'h0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fill: 7 strobes keep the queue filling.
    for (int i = 0; i < 7; i++) strobe();
    check("fill7_wr", 32'(wr_ptr), 32'd7);
    check("fill7_seq", 32'(sequencing), 32'd0);
    tick();
    check("fill7_seq_idle", 32'(sequencing), 32'd0);
    strobe();
    check("fill8_wr", 32'(wr_ptr), 32'd0);
    check("fill8_seq", 32'(sequencing), 32'd0);
    check("fill8_vld", 32'(out_vld), 32'd0);
    tick();
    check("fill8_seq2", 32'(sequencing), 32'd0);
    check("fill8_vld2", 32'(out_vld), 32'd0);

    // First pass: wr 0->1, base 1.
    strobe();
    check("p1_wr", 32'(wr_ptr), 32'd1);
    run_pass(1, 16'hA000, 16'h5000, 9'b0);
    tick();
    check("p1_idle_seq", 32'(sequencing), 32'd0);
    check("p1_idle_vld", 32'(out_vld), 32'd0);

    // Strobe mid-SEQ queues exactly one relaunch with base = wr_ptr = 3.
    strobe();
    run_pass(2, 16'hB000, 16'h6000, 9'b000001000);
    check("p2_wr", 32'(wr_ptr), 32'd3);
    tick();
    run_pass(3, 16'hC000, 16'h7000, 9'b0);
    check("p3_ovr", 32'(ovr), 32'd0);
    tick();
    check("p3_idle_seq", 32'(sequencing), 32'd0);

    // Two strobes in one SEQ: overrun, one extra pass from base 6 (wraps).
    strobe();
    run_pass(4, 16'hD000, 16'h1100, 9'b000100100);
    check("p4_wr", 32'(wr_ptr), 32'd6);
    check("p4_ovr", 32'(ovr), 32'(EXP_OVR));
    tick();
    run_pass(6, 16'hE000, 16'h2200, 9'b0);
    tick();
    check("p5_idle_seq", 32'(sequencing), 32'd0);
    tick();
    check("p5_idle_seq2", 32'(sequencing), 32'd0);
    check("p5_ovr", 32'(ovr), 32'(EXP_OVR));

    // wr_ptr 6->7, then a strobe at 7 wraps to 0.
    strobe();
    check("p6_wr", 32'(wr_ptr), 32'd7);
    run_pass(7, 16'h1234, 16'h4321, 9'b0);
    tick();
    strobe();
    check("p7_wr_wrap", 32'(wr_ptr), 32'd0);
    run_pass(0, 16'h2000, 16'h3000, 9'b0);

    // Strobe in GAP with nothing pending relaunches immediately.
    strobe();
    check("p8_wr", 32'(wr_ptr), 32'd1);
    run_pass(1, 16'h4000, 16'h8000, 9'b0);
    tick();
    check("p8_idle_seq", 32'(sequencing), 32'd0);

    // Asynchronous reset at seq_cnt=4.
    strobe();
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_seq", 32'(sequencing), 32'd1);
    check("pre_rst_rd", 32'(rd_ptr), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Refill required after reset.
    for (int i = 0; i < 7; i++) strobe();
    tick();
    check("refill7_seq", 32'(sequencing), 32'd0);
    strobe();
    check("refill8_seq", 32'(sequencing), 32'd0);
    check("refill8_wr", 32'(wr_ptr), 32'd0);
    strobe();
    check("refill_launch_seq", 32'(sequencing), 32'd1);
    check("refill_launch_rd", 32'(rd_ptr), 32'd1);
    check("refill_ovr", 32'(ovr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
